// File: rtl/rasterizer_pkg.sv
// Shared rasterizer types: set-up triangle, per-pixel bundle, bbox
// and traverser state, plus Q16.3 to pixel rounding helpers.
package rasterizer_pkg;

    // Vertex v0 and edge vectors, signed Q16.3
    typedef struct packed {
        logic signed [18:0] v0x;
        logic signed [18:0] v0y;
        logic signed [18:0] e0x;
        logic signed [18:0] e0y;
        logic signed [18:0] e1x;
        logic signed [18:0] e1y;
    } triangle_state_t;

    typedef struct packed {
        logic [15:0]     x;
        logic [15:0]     y;
        triangle_state_t triangle;
    } pixel_state_t;

    typedef struct packed {
        logic [15:0] min_x;
        logic [15:0] max_x;
        logic [15:0] min_y;
        logic [15:0] max_y;
    } bbox_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WALK
    } traverser_state_t;

    // ceil(v/8) of a 20-bit Q16.3 value; 18 bits holds -2^16..2^16
    function automatic logic signed [17:0] ceil_q3(logic signed [19:0] v);
        logic signed [20:0] s;
        s = v;
        return 18'((s + 21'sd7) >>> 3);
    endfunction

    function automatic logic signed [17:0] floor_q3(logic signed [19:0] v);
        logic signed [20:0] s;
        s = v;
        return 18'(s >>> 3);
    endfunction

endpackage

// File: rtl/pixel_traverser_if.sv
// Triangle-in / pixel-out handshake bundle of the pixel traverser.
// master: triangle source and pixel sink; slave: the traverser.
interface pixel_traverser_if;
    import rasterizer_pkg::*;

    triangle_state_t in_triangle;
    logic            in_valid;
    logic            in_ready;
    pixel_state_t    out_pixel;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;

    modport master (
        output in_triangle, in_valid, out_ready,
        input  in_ready, out_pixel, out_valid, out_last, busy
    );

    modport slave (
        input  in_triangle, in_valid, out_ready,
        output in_ready, out_pixel, out_valid, out_last, busy
    );

endinterface

// File: rtl/triangle_bbox.sv
// Combinational screen-clipped pixel bounding box of a triangle.
// tri_i: set-up triangle; bbox_o: clipped box; empty_o: no pixels.
module triangle_bbox
    import rasterizer_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  triangle_state_t tri_i,
    output bbox_t           bbox_o,
    output logic            empty_o
);

    localparam logic signed [17:0] XMAX = 18'(WIDTH - 1);
    localparam logic signed [17:0] YMAX = 18'(HEIGHT - 1);

    logic signed [19:0] x0, x1, x2, y0, y1, y2;
    logic signed [19:0] xmin, xmax, ymin, ymax;
    logic signed [17:0] lo_x, hi_x, lo_y, hi_y;
    logic signed [17:0] lo_xc, hi_xc, lo_yc, hi_yc;

    function automatic logic signed [19:0] min3(
        logic signed [19:0] a, logic signed [19:0] b, logic signed [19:0] c);
        logic signed [19:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [19:0] max3(
        logic signed [19:0] a, logic signed [19:0] b, logic signed [19:0] c);
        logic signed [19:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // 20-bit sums of 19-bit operands cannot overflow
    assign x0 = tri_i.v0x;
    assign y0 = tri_i.v0y;
    assign x1 = x0 + 20'(tri_i.e0x);
    assign y1 = y0 + 20'(tri_i.e0y);
    assign x2 = x0 + 20'(tri_i.e1x);
    assign y2 = y0 + 20'(tri_i.e1y);

    assign xmin = min3(x0, x1, x2);
    assign xmax = max3(x0, x1, x2);
    assign ymin = min3(y0, y1, y2);
    assign ymax = max3(y0, y1, y2);

    assign lo_x = ceil_q3(xmin);
    assign hi_x = floor_q3(xmax);
    assign lo_y = ceil_q3(ymin);
    assign hi_y = floor_q3(ymax);

    assign lo_xc = lo_x[17] ? 18'sd0 : lo_x;
    assign lo_yc = lo_y[17] ? 18'sd0 : lo_y;
    assign hi_xc = (hi_x > XMAX) ? XMAX : hi_x;
    assign hi_yc = (hi_y > YMAX) ? YMAX : hi_y;

    // Signed compare also catches boxes wholly off-screen
    assign empty_o = (lo_xc > hi_xc) || (lo_yc > hi_yc);

    assign bbox_o.min_x = 16'(lo_xc);
    assign bbox_o.max_x = 16'(hi_xc);
    assign bbox_o.min_y = 16'(lo_yc);
    assign bbox_o.max_y = 16'(hi_yc);

endmodule

// File: rtl/pixel_traverser.sv
// Walks a triangle's clipped bounding box in raster order, one pixel/cycle.
// clk/rst (sync, active-high); bus: triangle in, pixel out handshakes.
module pixel_traverser
    import rasterizer_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input logic               clk,
    input logic               rst,
    pixel_traverser_if.slave  bus
);

    traverser_state_t state_q;
    triangle_state_t  tri_q;
    logic [15:0]      min_x_q, max_x_q, max_y_q;
    logic [15:0]      cur_x_q, cur_y_q;
    bbox_t            bbox;
    logic             empty;

    triangle_bbox #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_bbox (
        .tri_i   (tri_q),
        .bbox_o  (bbox),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tri_q   <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            max_y_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        tri_q   <= bus.in_triangle;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    min_x_q <= bbox.min_x;
                    max_x_q <= bbox.max_x;
                    max_y_q <= bbox.max_y;
                    cur_x_q <= bbox.min_x;
                    cur_y_q <= bbox.min_y;
                    state_q <= empty ? IDLE : WALK;
                end
                WALK: begin
                    if (bus.out_ready) begin
                        if (cur_x_q < max_x_q) begin
                            cur_x_q <= cur_x_q + 16'd1;
                        end else if (cur_y_q < max_y_q) begin
                            cur_x_q <= min_x_q;
                            cur_y_q <= cur_y_q + 16'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == WALK);
    assign bus.out_last  = (state_q == WALK) &&
                           (cur_x_q == max_x_q) &&
                           (cur_y_q == max_y_q);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_pixel = '{x: cur_x_q, y: cur_y_q, triangle: tri_q};

endmodule

// File: tb/tb_pixel_traverser.sv
// Directed and random stimulus for pixel_traverser against a
// bounding-box reference model built from integer arithmetic.
module tb_pixel_traverser;
    import rasterizer_pkg::*;

    localparam int W = 320;
    localparam int H = 240;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } exp_px_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_px_t exp_q[$];

    pixel_traverser_if bus();

    pixel_traverser #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic triangle_state_t mk(int v0x, int v0y, int e0x,
                                           int e0y, int e1x, int e1y);
        triangle_state_t t;
        t.v0x = 19'(v0x); t.v0y = 19'(v0y);
        t.e0x = 19'(e0x); t.e0y = 19'(e0y);
        t.e1x = 19'(e1x); t.e1y = 19'(e1y);
        return t;
    endfunction

    function automatic triangle_state_t rand_tri();
        int vx, vy;
        vx = int'($urandom_range(360 * 8)) - 20 * 8;
        vy = int'($urandom_range(280 * 8)) - 20 * 8;
        return mk(vx, vy,
                  int'($urandom_range(320)) - 160, int'($urandom_range(320)) - 160,
                  int'($urandom_range(320)) - 160, int'($urandom_range(320)) - 160);
    endfunction

    function automatic int fdiv8(int a);
        return (a >= 0) ? a / 8 : -((-a + 7) / 8);
    endfunction

    // Expected raster-order pixel list for a triangle
    function automatic void build(triangle_state_t t);
        int xs[3], ys[3];
        int lx, hx, ly, hy;
        exp_px_t p;
        exp_q.delete();
        xs[0] = $signed(t.v0x); ys[0] = $signed(t.v0y);
        xs[1] = xs[0] + $signed(t.e0x); ys[1] = ys[0] + $signed(t.e0y);
        xs[2] = xs[0] + $signed(t.e1x); ys[2] = ys[0] + $signed(t.e1y);
        lx = xs[0]; hx = xs[0]; ly = ys[0]; hy = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < lx) lx = xs[i];
            if (xs[i] > hx) hx = xs[i];
            if (ys[i] < ly) ly = ys[i];
            if (ys[i] > hy) hy = ys[i];
        end
        lx = -fdiv8(-lx); hx = fdiv8(hx);
        ly = -fdiv8(-ly); hy = fdiv8(hy);
        if (lx < 0) lx = 0;
        if (ly < 0) ly = 0;
        if (hx > W - 1) hx = W - 1;
        if (hy > H - 1) hy = H - 1;
        for (int y = ly; y <= hy; y++)
            for (int x = lx; x <= hx; x++) begin
                p.x = 16'(x);
                p.y = 16'(y);
                p.last = (x == hx) && (y == hy);
                exp_q.push_back(p);
            end
    endfunction

    // Present t at this negedge; returns at negedge of cycle accept+2
    task automatic accept(input triangle_state_t t);
        chk("in_ready_idle", 128'(bus.in_ready), 128'(1'b1));
        bus.in_triangle = t;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_triangle = rand_tri();
        chk("setup_no_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("setup_busy", 128'(bus.busy), 128'(1'b1));
        @(negedge clk);
    endtask

    task automatic walk(input triangle_state_t t, input int pct,
                        input int stop_after, output int hs);
        int budget;
        bit stalled;
        logic [32:0] held;
        build(t);
        hs = 0;
        stalled = 0;
        held = '0;
        if (exp_q.size() == 0) begin
            chk("empty_no_valid", 128'(bus.out_valid), 128'(1'b0));
            chk("empty_in_ready", 128'(bus.in_ready), 128'(1'b1));
            return;
        end
        budget = 20000;
        while (exp_q.size() != 0 && budget > 0 &&
               !(stop_after != 0 && hs == stop_after)) begin
            chk("out_valid_held", 128'(bus.out_valid), 128'(1'b1));
            if (stalled)
                chk("stall_stable", 128'({bus.out_pixel.x, bus.out_pixel.y,
                    bus.out_last}), 128'(held));
            bus.out_ready = ($urandom_range(99) < pct);
            if (bus.out_ready) begin
                chk("px_x", 128'(bus.out_pixel.x), 128'(exp_q[0].x));
                chk("px_y", 128'(bus.out_pixel.y), 128'(exp_q[0].y));
                chk("px_last", 128'(bus.out_last), 128'(exp_q[0].last));
                chk("px_tri", 128'(bus.out_pixel.triangle), 128'(t));
                void'(exp_q.pop_front());
                hs++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = {bus.out_pixel.x, bus.out_pixel.y, bus.out_last};
            end
            @(negedge clk);
            budget--;
        end
        bus.out_ready = 1'b0;
        if (budget == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL walk_timeout: observed %0d pixels left expected 0",
                   exp_q.size());
        end
        if (stop_after == 0) begin
            chk("done_in_ready", 128'(bus.in_ready), 128'(1'b1));
            chk("done_no_valid", 128'(bus.out_valid), 128'(1'b0));
            chk("done_busy", 128'(bus.busy), 128'(1'b0));
        end
    endtask

    task automatic run(input triangle_state_t t, input int pct);
        int hs;
        accept(t);
        walk(t, pct, 0, hs);
    endtask

    initial begin
        triangle_state_t box, ta, tb;
        int hs;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_triangle = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("rst_out_last", 128'(bus.out_last), 128'(1'b0));
        chk("rst_busy", 128'(bus.busy), 128'(1'b0));
        chk("rst_pixel", 128'(bus.out_pixel), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        box = mk(16, 24, 32, 0, 0, 16);
        run(box, 100);
        run(mk(13, 24, 32, 0, 0, 8), 100);
        run(mk(16, 16, 8, 0, 0, 8), 100);
        run(mk(-40, 8, 64, 0, 0, 8), 100);
        run(mk(318 * 8, 0, 96, 0, 0, 8), 100);
        run(mk(238 * 8, 238 * 8, 0, 40, 8, 0), 100);
        run(mk(-200, 16, 80, 0, 0, 16), 100);
        run(mk(80, 80, 4, 0, 0, 4), 100);

        accept(box);
        walk(box, 50, 0, hs);
        chk("bp_handshakes", 128'(hs), 128'(15));

        accept(box);
        walk(box, 100, 5, hs);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("midrst_busy", 128'(bus.busy), 128'(1'b0));
        chk("midrst_in_ready", 128'(bus.in_ready), 128'(1'b1));
        chk("midrst_last", 128'(bus.out_last), 128'(1'b0));
        run(mk(40, 40, 16, 0, 8, 16), 100);

        ta = mk(16, 24, 16, 0, 0, 8);
        tb = mk(100, 60, 8, 8, -8, 0);
        chk("b2b_in_ready", 128'(bus.in_ready), 128'(1'b1));
        bus.in_triangle = ta;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_triangle = tb;
        chk("b2b_setup_a", 128'(bus.out_valid), 128'(1'b0));
        @(negedge clk);
        walk(ta, 100, 0, hs);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("b2b_accepted", 128'(bus.in_ready), 128'(1'b0));
        chk("b2b_setup_b", 128'(bus.out_valid), 128'(1'b0));
        @(negedge clk);
        walk(tb, 100, 0, hs);

        for (int i = 0; i < 8; i++)
            run(rand_tri(), 50);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
